// File: rtl/calc2_port_driver.sv
// Purpose: plays one (cmd, op1, op2, tag) operation onto a calc2 request port, then returns the matching response.
// Latency: accept edge to rsp_valid is 3 + N cycles (N = WAIT cycles to the match, TIMEOUT_CYCLES on timeout).
// Backpressure: txn_ready is high only in IDLE; one transaction in flight, txn_valid ignored while busy.
module calc2_port_driver #(
    parameter int TIMEOUT_CYCLES = 10,
    parameter int CNT_W          = 4
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        txn_valid,
    output logic        txn_ready,
    input  logic [3:0]  txn_cmd,
    input  logic [31:0] txn_op1,
    input  logic [31:0] txn_op2,
    input  logic [1:0]  txn_tag,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    output logic [1:0]  req_tag_out,
    input  logic [1:0]  resp_in,
    input  logic [31:0] resp_data_in,
    input  logic [1:0]  resp_tag_in,
    output logic        rsp_valid,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_tag,
    output logic        rsp_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [CNT_W:0] TO_LIM = (CNT_W + 1)'(TIMEOUT_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic [31:0]      op2_q;
    logic [1:0]       tag_q;
    logic             match;
    logic             expire;

    always_comb begin
        cnt_inc   = {1'b0, cnt} + 1'b1;
        match     = (resp_in != 2'd0) && (resp_tag_in == tag_q);
        expire    = (cnt_inc == TO_LIM);
        state_nxt = state;
        case (state)
            S_IDLE:  if (txn_valid) state_nxt = S_CMD;
            S_CMD:   state_nxt = S_DATA;
            S_DATA:  state_nxt = S_WAIT;
            S_WAIT:  if (match || expire) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            op2_q        <= '0;
            tag_q        <= '0;
            txn_ready    <= 1'b1;
            req_cmd_out  <= '0;
            req_data_out <= '0;
            req_tag_out  <= '0;
            rsp_valid    <= 1'b0;
            rsp_resp     <= '0;
            rsp_data     <= '0;
            rsp_tag      <= '0;
            rsp_timeout  <= 1'b0;
        end else begin
            txn_ready <= (state_nxt == S_IDLE);
            // rsp_* are loaded on the WAIT exit edge, so they are already stable when the pulse rises
            rsp_valid <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (txn_valid) begin
                        op2_q        <= txn_op2;
                        tag_q        <= txn_tag;
                        req_cmd_out  <= txn_cmd;
                        req_data_out <= txn_op1;
                        req_tag_out  <= txn_tag;
                    end
                end
                S_CMD: begin
                    req_cmd_out  <= '0;
                    req_data_out <= op2_q;
                end
                S_DATA: begin
                    req_cmd_out  <= '0;
                    req_data_out <= '0;
                    req_tag_out  <= '0;
                    cnt          <= '0;
                end
                S_WAIT: begin
                    // a match on the expiring cycle takes priority over the timeout
                    if (match) begin
                        rsp_resp    <= resp_in;
                        rsp_data    <= resp_data_in;
                        rsp_tag     <= tag_q;
                        rsp_timeout <= 1'b0;
                    end else if (expire) begin
                        rsp_resp    <= '0;
                        rsp_data    <= '0;
                        rsp_tag     <= tag_q;
                        rsp_timeout <= 1'b1;
                        cnt         <= cnt_inc[CNT_W-1:0];
                    end else begin
                        cnt <= cnt_inc[CNT_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc2_port_driver.sv
// Bench for calc2_port_driver: the bench plays the calc2_top responder; a scoreboard holds expected results.
module tb_calc2_port_driver;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic        txn_valid = 1'b0;
    logic        txn_ready;
    logic [3:0]  txn_cmd = '0;
    logic [31:0] txn_op1 = '0;
    logic [31:0] txn_op2 = '0;
    logic [1:0]  txn_tag = '0;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  req_tag_out;
    logic [1:0]  resp_in = '0;
    logic [31:0] resp_data_in = '0;
    logic [1:0]  resp_tag_in = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_tag;
    logic        rsp_timeout;

    calc2_port_driver #(.TIMEOUT_CYCLES(10), .CNT_W(4)) dut (
        .c_clk(c_clk), .reset(reset),
        .txn_valid(txn_valid), .txn_ready(txn_ready),
        .txn_cmd(txn_cmd), .txn_op1(txn_op1), .txn_op2(txn_op2), .txn_tag(txn_tag),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
        .resp_in(resp_in), .resp_data_in(resp_data_in), .resp_tag_in(resp_tag_in),
        .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
        logic        to;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge c_clk) cyc <= cyc + 1;

    // Scoreboard monitor: every rsp_valid cycle must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(posedge c_clk);
            #1;
            if (rsp_valid === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp_valid: rsp_valid=1 at cycle %0d, required no response", cyc);
                end else begin
                    e = sb.pop_front();
                    n_chk++;
                    if ({rsp_resp, rsp_data, rsp_tag, rsp_timeout} !== {e.resp, e.data, e.tag, e.to}) begin
                        n_fail++;
                        $display("FAIL rsp_fields: got resp=%0d data=%h tag=%0d to=%0b, required resp=%0d data=%h tag=%0d to=%0b",
                                 rsp_resp, rsp_data, rsp_tag, rsp_timeout, e.resp, e.data, e.tag, e.to);
                    end
                    n_chk++;
                    if (cyc !== e.at) begin
                        n_fail++;
                        $display("FAIL rsp_latency: got cycle %0d, required %0d", cyc, e.at);
                    end
                    n_chk++;
                    if (txn_ready !== 1'b1) begin
                        n_fail++;
                        $display("FAIL ready_after_done: got %b, required 1", txn_ready);
                    end
                end
            end
        end
    end

    // Accepts one transaction and checks the two-cycle port sequence; returns in WAIT cycle 1.
    task automatic do_txn(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                          input logic [1:0] tag, input bit noise, input bit push,
                          input logic [1:0] e_resp, input logic [31:0] e_data, input logic e_to, input int n);
        exp_t e;
        @(negedge c_clk);
        n_chk++;
        if (txn_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_idle: got %b, required 1", txn_ready);
        end
        txn_valid = 1'b1;
        txn_cmd = cmd;
        txn_op1 = op1;
        txn_op2 = op2;
        txn_tag = tag;
        @(posedge c_clk);
        #1;
        acc_cyc = cyc;
        if (push) begin
            e.resp = e_resp; e.data = e_data; e.tag = tag; e.to = e_to; e.at = acc_cyc + 3 + n;
            sb.push_back(e);
        end
        txn_valid = 1'b0;
        txn_cmd = 4'hf;
        txn_op1 = 32'hdeadbeef;
        txn_op2 = 32'hcafef00d;
        txn_tag = ~tag;
        n_chk++;
        if ({req_cmd_out, req_data_out, req_tag_out, txn_ready} !== {cmd, op1, tag, 1'b0}) begin
            n_fail++;
            $display("FAIL port_cmd_phase: got cmd=%h data=%h tag=%0d ready=%b, required cmd=%h data=%h tag=%0d ready=0",
                     req_cmd_out, req_data_out, req_tag_out, txn_ready, cmd, op1, tag);
        end
        if (noise) begin
            resp_in = 2'd1;
            resp_data_in = 32'h0bad0bad;
            resp_tag_in = tag;
        end
        @(posedge c_clk);
        #1;
        n_chk++;
        if ({req_cmd_out, req_data_out, req_tag_out} !== {4'h0, op2, tag}) begin
            n_fail++;
            $display("FAIL port_data_phase: got cmd=%h data=%h tag=%0d, required cmd=0 data=%h tag=%0d",
                     req_cmd_out, req_data_out, req_tag_out, op2, tag);
        end
        @(posedge c_clk);
        #1;
        resp_in = '0;
        resp_data_in = '0;
        resp_tag_in = '0;
        n_chk++;
        if ({req_cmd_out, req_data_out, req_tag_out} !== 38'd0) begin
            n_fail++;
            $display("FAIL port_idle_wait: got cmd=%h data=%h tag=%0d, required all 0",
                     req_cmd_out, req_data_out, req_tag_out);
        end
    endtask

    // Presents a response for one cycle on the k-th WAIT cycle counted from the current one.
    task automatic respond(input int k, input logic [1:0] r, input logic [31:0] d, input logic [1:0] t);
        repeat (k - 1) begin
            @(posedge c_clk);
            #1;
        end
        resp_in = r;
        resp_data_in = d;
        resp_tag_in = t;
        @(posedge c_clk);
        #1;
        resp_in = '0;
        resp_data_in = '0;
        resp_tag_in = '0;
    endtask

    task automatic wait_done(input string name);
        int i = 0;
        while (sb.size() != 0 && i < 40) begin
            @(negedge c_clk);
            i++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_no_rsp: %0d results outstanding after 40 cycles, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge c_clk);
        #1;
        n_chk++;
        if ({req_cmd_out, req_data_out, req_tag_out, rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_timeout, txn_ready}
            !== {38'd0, 1'b0, 2'd0, 32'd0, 2'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_held: got req=%h/%h/%0d rsp=%b/%0d/%h/%0d/%b ready=%b, required zeros and ready=1",
                     req_cmd_out, req_data_out, req_tag_out, rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_timeout, txn_ready);
        end
        @(negedge c_clk);
        reset = 1'b1;
        @(posedge c_clk);
        #1;
        n_chk++;
        if ({req_cmd_out, req_data_out, req_tag_out, rsp_valid, rsp_data, rsp_timeout, txn_ready}
            !== {38'd0, 1'b0, 32'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release: got req=%h/%h rsp_valid=%b data=%h ready=%b, required zeros and ready=1",
                     req_cmd_out, req_data_out, rsp_valid, rsp_data, txn_ready);
        end
    endtask

    task automatic test_add();
        do_txn(4'd1, 32'h30, 32'h20, 2'd1, 1'b0, 1'b1, 2'd1, 32'h50, 1'b0, 1);
        respond(1, 2'd1, 32'h50, 2'd1);
        wait_done("add");
        @(posedge c_clk);
        #1;
        n_chk++;
        if ({rsp_valid, rsp_data} !== {1'b0, 32'h50}) begin
            n_fail++;
            $display("FAIL rsp_hold: got valid=%b data=%h, required valid=0 data=00000050", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_timeout();
        do_txn(4'd6, 32'h80, 32'h2, 2'd1, 1'b1, 1'b1, 2'd0, 32'd0, 1'b1, 10);
        wait_done("timeout");
    endtask

    task automatic test_wrong_tag();
        do_txn(4'd2, 32'h9, 32'h4, 2'd1, 1'b0, 1'b1, 2'd1, 32'h5, 1'b0, 3);
        respond(1, 2'd1, 32'hdead, 2'd2);
        respond(2, 2'd1, 32'h5, 2'd1);
        wait_done("wrong_tag");
    endtask

    task automatic test_late_match();
        do_txn(4'd5, 32'h1, 32'h4, 2'd3, 1'b0, 1'b1, 2'd2, 32'h10, 1'b0, 10);
        respond(10, 2'd2, 32'h10, 2'd3);
        wait_done("late_match");
    endtask

    task automatic test_reset_abort();
        do_txn(4'd1, 32'h7, 32'h8, 2'd2, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 0);
        @(posedge c_clk);
        #2;
        reset = 1'b0;
        resp_in = 2'd1;
        resp_data_in = 32'hf;
        resp_tag_in = 2'd2;
        #1;
        n_chk++;
        if ({req_cmd_out, req_data_out, req_tag_out, rsp_valid, txn_ready} !== {38'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_async: got req=%h/%h/%0d valid=%b ready=%b, required zeros and ready=1",
                     req_cmd_out, req_data_out, req_tag_out, rsp_valid, txn_ready);
        end
        repeat (2) @(posedge c_clk);
        @(negedge c_clk);
        reset = 1'b1;
        resp_in = '0;
        resp_data_in = '0;
        resp_tag_in = '0;
        do_txn(4'd2, 32'h5, 32'h3, 2'd0, 1'b0, 1'b1, 2'd1, 32'h2, 1'b0, 1);
        respond(1, 2'd1, 32'h2, 2'd0);
        wait_done("abort_retry");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_timeout();
        test_wrong_tag();
        test_late_match();
        test_reset_abort();
        repeat (3) @(posedge c_clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
